// File: rtl/fizzbuzz_pkg.sv
// Shared types and elaboration helpers for the FizzBuzz stream generator.
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_NUM      = 2'd0,
    KIND_FIZZ     = 2'd1,
    KIND_BUZZ     = 2'd2,
    KIND_FIZZBUZZ = 2'd3
  } kind_e;

  // Bits needed to hold a residue 0..m-1 (at least one bit).
  function automatic int unsigned res_width(input int unsigned m);
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  // Parameter legality: divisors >= 2, LIMIT >= 1 and representable in WIDTH bits.
  function automatic bit params_ok(input int unsigned width, input int unsigned fizz,
                                   input int unsigned buzz, input int unsigned limit);
    return (width >= 1) && (width <= 32) && (fizz >= 2) && (buzz >= 2) && (limit >= 1) &&
           (64'(limit) < (64'd1 << width));
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Residue counter modulo MOD: loads INIT, increments with wrap from MOD-1 to 0.
module mod_counter
  import fizzbuzz_pkg::*;
#(
  parameter int unsigned MOD  = 3,
  parameter int unsigned INIT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      inc,
  output logic [res_width(MOD)-1:0] res
);

  localparam int unsigned RW = res_width(MOD);

  logic [RW-1:0] r_res;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      r_res <= RW'(INIT);
    end else if (inc) begin
      r_res <= (r_res == RW'(MOD - 1)) ? '0 : r_res + RW'(1);
    end
  end

  assign res = r_res;

endmodule

// File: rtl/fizzbuzz_gen.sv
// FizzBuzz sequencer: streams 1..LIMIT over valid/ready, classified via residue counters.
module fizzbuzz_gen
  import fizzbuzz_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FIZZ  = 3,
  parameter int unsigned BUZZ  = 5,
  parameter int unsigned LIMIT = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_value,
  output logic [1:0]       out_kind,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned FW = res_width(FIZZ);
  localparam int unsigned BW = res_width(BUZZ);

  if (!params_ok(WIDTH, FIZZ, BUZZ, LIMIT)) begin : g_bad_params
    $error("fizzbuzz_gen: illegal parameter combination");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] w_value_nxt;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_inc;
  logic             w_hs;
  logic [FW-1:0]    w_fizz_res;
  logic [BW-1:0]    w_buzz_res;

  assign w_hs = r_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_RUN;
          w_value_nxt = WIDTH'(1);
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        // Abort wins over advancing; a coincident handshake is simply the final beat.
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_hs) begin
          if (r_value == WIDTH'(LIMIT)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_value_nxt = r_value + WIDTH'(1);
            w_inc       = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output registers track the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_value <= w_value_nxt;
      r_valid <= (w_state_nxt == S_RUN);
      r_last  <= (w_value_nxt == WIDTH'(LIMIT));
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  mod_counter #(
    .MOD  (FIZZ),
    .INIT (1 % FIZZ)
  ) u_fizz_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .inc  (w_inc),
    .res  (w_fizz_res)
  );

  mod_counter #(
    .MOD  (BUZZ),
    .INIT (1 % BUZZ)
  ) u_buzz_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .inc  (w_inc),
    .res  (w_buzz_res)
  );

  // Kind only meaningful with a beat present; forced to number otherwise.
  assign out_kind  = r_valid ? {(w_buzz_res == '0), (w_fizz_res == '0)} : KIND_NUM;
  assign out_valid = r_valid;
  assign out_value = r_value;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_fizzbuzz_gen.sv
// Directed bench for fizzbuzz_gen: default build plus a small WIDTH=3/FIZZ=2/BUZZ=3/LIMIT=6 build.
module tb_fizzbuzz_gen;

  logic       clk = 1'b0;
  logic       rst, start, abort, ready;
  logic       valid, last, busy, done;
  logic [7:0] value;
  logic [1:0] kind;

  logic       s_start, s_abort, s_ready;
  logic       s_valid, s_last, s_busy, s_done;
  logic [2:0] s_value;
  logic [1:0] s_kind;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fizzbuzz_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .out_ready (ready),
    .out_valid (valid),
    .out_value (value),
    .out_kind  (kind),
    .out_last  (last),
    .busy      (busy),
    .done      (done)
  );

  fizzbuzz_gen #(
    .WIDTH (3),
    .FIZZ  (2),
    .BUZZ  (3),
    .LIMIT (6)
  ) dut_s (
    .clk       (clk),
    .rst       (rst),
    .start     (s_start),
    .abort     (s_abort),
    .out_ready (s_ready),
    .out_valid (s_valid),
    .out_value (s_value),
    .out_kind  (s_kind),
    .out_last  (s_last),
    .busy      (s_busy),
    .done      (s_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_value(input int v);
    int k;
    k = 0;
    while (!(valid && value == 8'(v)) && k < 300) begin
      step();
      k++;
    end
    check($sformatf("reach_%0d", v), 32'(value), 32'(v));
  endtask

  function automatic logic [1:0] exp_kind(input int n);
    return {(n % 5) == 0, (n % 3) == 0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] sk[6];
    sk = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_kind",  32'(kind),  32'd0);
    check("rst_last",  32'(last),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    rst = 1'b0;
    step();

    // Small build: kinds 00,01,10,01,00,11 with last only on 6.
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("s_valid", 32'(s_valid), 32'd1);
      check("s_value", 32'(s_value), 32'(i + 1));
      check("s_kind",  32'(s_kind),  32'(sk[i]));
      check("s_last",  32'(s_last),  32'(i == 5));
      step();
    end
    check("s_done", 32'(s_done), 32'd1);
    step();
    check("s_idle_busy", 32'(s_busy), 32'd0);

    // Full default run; start pulses during RUN (beat 50) and DONE must be ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      check("valid", 32'(valid), 32'd1);
      check("value", 32'(value), 32'(n));
      check("kind",  32'(kind),  32'(exp_kind(n)));
      check("last",  32'(last),  32'(n == 100));
      check("done_early", 32'(done), 32'd0);
      if (n == 3)   check("kind3",   32'(kind), 32'd1);
      if (n == 5)   check("kind5",   32'(kind), 32'd2);
      if (n == 7)   check("kind7",   32'(kind), 32'd0);
      if (n == 15)  check("kind15",  32'(kind), 32'd3);
      if (n == 100) check("kind100", 32'(kind), 32'd2);
      start = (n == 50);
      step();
    end
    start = 1'b1;
    check("done_pulse", 32'(done),  32'd1);
    check("done_valid", 32'(valid), 32'd0);
    check("done_busy",  32'(busy),  32'd1);
    step();
    start = 1'b0;
    check("post_done",  32'(done),  32'd0);
    check("post_busy",  32'(busy),  32'd0);
    check("post_valid", 32'(valid), 32'd0);
    step();
    check("start_in_done_ignored", 32'(valid), 32'd0);

    // Backpressure: hold 14 for four cycles, then 15 (fizzbuzz).
    start = 1'b1;
    step();
    start = 1'b0;
    wait_value(14);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_value", 32'(value), 32'd14);
      check("bp_kind",  32'(kind),  32'd0);
      check("bp_valid", 32'(valid), 32'd1);
    end
    ready = 1'b1;
    step();
    check("bp_next_value", 32'(value), 32'd15);
    check("bp_next_kind",  32'(kind),  32'd3);

    // Reset mid-run overrides start and abort.
    wait_value(42);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_value", 32'(value), 32'd0);
    check("mrst_kind",  32'(kind),  32'd0);
    check("mrst_last",  32'(last),  32'd0);
    check("mrst_busy",  32'(busy),  32'd0);
    check("mrst_done",  32'(done),  32'd0);
    step();
    check("mrst_done2", 32'(done), 32'd0);

    // start together with abort in IDLE stays idle.
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("sa_valid", 32'(valid), 32'd0);
    check("sa_busy",  32'(busy),  32'd0);

    // Abort at value 7, then restart from 1.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_value", 32'(value), 32'd1);
    wait_value(7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    step();
    check("abort_done2", 32'(done),  32'd0);
    check("abort_idle",  32'(valid), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("abort_restart_valid", 32'(valid), 32'd1);
    check("abort_restart_value", 32'(value), 32'd1);
    check("abort_restart_kind",  32'(kind),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
